// File: rtl/seg_decode_monitor.sv
// rtl/seg_decode_monitor.sv - seven-segment display observer that decodes, debounces and classifies digit changes
//
// Purpose:
//   Watches the segment drive of a single seven-segment digit, decodes the
//   sampled pattern to a hex value, qualifies it over STABLE_SAMPLES
//   consecutive identical samples, then reports the accepted digit together
//   with a classification of the step from the previous accepted digit
//   (up / down / back-to-zero / hold) and saturating event counters.
//
// Parameters:
//   STABLE_SAMPLES  consecutive identical sampled patterns before acceptance (1..15)
//   ACTIVE_LOW      1: segments_in is inverted before decoding
//
// Ports:
//   clk_1hz          in   1  clock, all state changes on rising edge
//   reset_button     in   1  asynchronous active-high reset
//   segments_in      in   7  segment drive {g,f,e,d,c,b,a}
//   sample_en        in   1  sample strobe, segments_in looked at only when high
//   digit_out        out  4  last accepted hex digit
//   digit_valid      out  1  a digit has been accepted since reset
//   dir_out          out  2  00 hold/first, 01 up, 10 down, 11 back to zero
//   change_pulse     out  1  accepted digit differs from the previous one
//   invalid_pattern  out  1  sampled pattern is not a hex glyph
//   up_count         out  8  saturating count of up steps
//   down_count       out  8  saturating count of down steps
//   err_count        out  8  saturating count of invalid patterns and unclassified jumps

module seg_decode_monitor #(
  parameter int STABLE_SAMPLES = 2,
  parameter bit ACTIVE_LOW     = 1
) (
  input  logic       clk_1hz,
  input  logic       reset_button,
  input  logic [6:0] segments_in,
  input  logic       sample_en,
  output logic [3:0] digit_out,
  output logic       digit_valid,
  output logic [1:0] dir_out,
  output logic       change_pulse,
  output logic       invalid_pattern,
  output logic [7:0] up_count,
  output logic [7:0] down_count,
  output logic [7:0] err_count
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    LOCKED = 2'd2
  } state_t;

  localparam logic [1:0] DIR_HOLD = 2'b00;
  localparam logic [1:0] DIR_UP   = 2'b01;
  localparam logic [1:0] DIR_DOWN = 2'b10;
  localparam logic [1:0] DIR_ZERO = 2'b11;

  // Run target as a 4-bit value; a single-sample target means every fresh
  // candidate is accepted on the edge it is first seen.
  localparam logic [3:0] STABLE_TARGET = 4'(STABLE_SAMPLES);
  localparam bit         ACCEPT_FIRST  = (STABLE_SAMPLES <= 1);

  // Returns {valid, digit} for an active-high gfedcba pattern.
  function automatic logic [4:0] decode_seg(input logic [6:0] p);
    logic [4:0] r;
    case (p)
      7'h3F:   r = 5'h10;
      7'h06:   r = 5'h11;
      7'h5B:   r = 5'h12;
      7'h4F:   r = 5'h13;
      7'h66:   r = 5'h14;
      7'h6D:   r = 5'h15;
      7'h7D:   r = 5'h16;
      7'h07:   r = 5'h17;
      7'h7F:   r = 5'h18;
      7'h6F:   r = 5'h19;
      7'h77:   r = 5'h1A;
      7'h7C:   r = 5'h1B;
      7'h39:   r = 5'h1C;
      7'h5E:   r = 5'h1D;
      7'h79:   r = 5'h1E;
      7'h71:   r = 5'h1F;
      default: r = 5'h00;
    endcase
    return r;
  endfunction

  function automatic logic [7:0] sat_inc(input logic [7:0] c);
    return (c == 8'hFF) ? c : c + 8'd1;
  endfunction

  state_t     state, state_next;
  logic [3:0] cand, cand_next;
  logic [3:0] run, run_next;
  logic [3:0] run_inc;

  logic [3:0] digit_next;
  logic       valid_next;
  logic [1:0] dir_next;
  logic       change_next;
  logic       invalid_next;
  logic [7:0] up_next;
  logic [7:0] down_next;
  logic [7:0] err_next;

  logic [6:0] pat;
  logic [4:0] dec;
  logic       pat_valid;
  logic [3:0] pat_digit;
  logic       accept;

  assign pat       = ACTIVE_LOW ? ~segments_in : segments_in;
  assign dec       = decode_seg(pat);
  assign pat_valid = dec[4];
  assign pat_digit = dec[3:0];
  assign run_inc   = run + 4'd1;

  always_ff @(posedge clk_1hz or posedge reset_button) begin
    if (reset_button) begin
      state           <= IDLE;
      cand            <= 4'd0;
      run             <= 4'd0;
      digit_out       <= 4'd0;
      digit_valid     <= 1'b0;
      dir_out         <= DIR_HOLD;
      change_pulse    <= 1'b0;
      invalid_pattern <= 1'b0;
      up_count        <= 8'd0;
      down_count      <= 8'd0;
      err_count       <= 8'd0;
    end else begin
      state           <= state_next;
      cand            <= cand_next;
      run             <= run_next;
      digit_out       <= digit_next;
      digit_valid     <= valid_next;
      dir_out         <= dir_next;
      change_pulse    <= change_next;
      invalid_pattern <= invalid_next;
      up_count        <= up_next;
      down_count      <= down_next;
      err_count       <= err_next;
    end
  end

  always_comb begin
    state_next   = state;
    cand_next    = cand;
    run_next     = run;
    digit_next   = digit_out;
    valid_next   = digit_valid;
    dir_next     = dir_out;
    change_next  = 1'b0;
    invalid_next = 1'b0;
    up_next      = up_count;
    down_next    = down_count;
    err_next     = err_count;
    accept       = 1'b0;

    if (sample_en) begin
      if (!pat_valid) begin
        // A bad glyph breaks any qualification in progress.
        invalid_next = 1'b1;
        err_next     = sat_inc(err_count);
        cand_next    = 4'd0;
        run_next     = 4'd0;
        state_next   = digit_valid ? LOCKED : IDLE;
      end else begin
        case (state)
          IDLE: begin
            cand_next  = pat_digit;
            run_next   = 4'd1;
            state_next = SETTLE;
            accept     = ACCEPT_FIRST;
          end
          SETTLE: begin
            if (pat_digit == cand) begin
              run_next = run_inc;
              accept   = (run_inc >= STABLE_TARGET);
            end else begin
              cand_next = pat_digit;
              run_next  = 4'd1;
              accept    = ACCEPT_FIRST;
            end
          end
          LOCKED: begin
            if (pat_digit == digit_out) begin
              cand_next = 4'd0;
              run_next  = 4'd0;
            end else begin
              cand_next  = pat_digit;
              run_next   = 4'd1;
              state_next = SETTLE;
              accept     = ACCEPT_FIRST;
            end
          end
          default: begin
            state_next = IDLE;
            cand_next  = 4'd0;
            run_next   = 4'd0;
          end
        endcase
      end
    end

    if (accept) begin
      state_next = LOCKED;
      cand_next  = 4'd0;
      run_next   = 4'd0;
      digit_next = pat_digit;
      valid_next = 1'b1;
      if (!digit_valid || pat_digit == digit_out) begin
        // First digit after reset, or the same digit re-qualified after a
        // transient candidate: nothing moved.
        dir_next = DIR_HOLD;
      end else begin
        change_next = 1'b1;
        // Priority: wrap-up (F->0) is an up step, then any other landing on
        // zero is a counter reset, then a single step down.
        if (pat_digit == digit_out + 4'd1) begin
          dir_next = DIR_UP;
          up_next  = sat_inc(up_count);
        end else if (pat_digit == 4'd0) begin
          dir_next = DIR_ZERO;
        end else if (pat_digit == digit_out - 4'd1) begin
          dir_next  = DIR_DOWN;
          down_next = sat_inc(down_count);
        end else begin
          dir_next = DIR_HOLD;
          err_next = sat_inc(err_count);
        end
      end
    end
  end

endmodule

// File: tb/tb_seg_decode_monitor.sv
// tb/tb_seg_decode_monitor.sv - self-checking bench for seg_decode_monitor against a behavioural model

module tb_seg_decode_monitor;

  localparam int STABLE = 2;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic [6:0] seg;
  logic [6:0] seg_n;

  always #5 clk = ~clk;
  assign seg_n = ~seg;

  // Instance a sees active-high drive, instance b the same glyphs active-low.
  logic [3:0] a_digit, b_digit;
  logic       a_valid, b_valid;
  logic [1:0] a_dir, b_dir;
  logic       a_cp, b_cp;
  logic       a_inv, b_inv;
  logic [7:0] a_up, a_down, a_err, b_up, b_down, b_err;

  seg_decode_monitor #(.STABLE_SAMPLES(STABLE), .ACTIVE_LOW(1'b0)) dut_a (
    .clk_1hz(clk), .reset_button(rst), .segments_in(seg), .sample_en(en),
    .digit_out(a_digit), .digit_valid(a_valid), .dir_out(a_dir),
    .change_pulse(a_cp), .invalid_pattern(a_inv),
    .up_count(a_up), .down_count(a_down), .err_count(a_err)
  );

  seg_decode_monitor #(.STABLE_SAMPLES(STABLE), .ACTIVE_LOW(1'b1)) dut_b (
    .clk_1hz(clk), .reset_button(rst), .segments_in(seg_n), .sample_en(en),
    .digit_out(b_digit), .digit_valid(b_valid), .dir_out(b_dir),
    .change_pulse(b_cp), .invalid_pattern(b_inv),
    .up_count(b_up), .down_count(b_down), .err_count(b_err)
  );

  logic [6:0] tab [0:15] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                             7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  int total = 0;
  int bad   = 0;

  // Model state: what the outputs must be, plus the current qualification streak.
  int m_digit, m_valid, m_dir, m_cp, m_inv, m_up, m_down, m_err;
  int m_last, m_streak;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  function automatic int dec(input logic [6:0] p);
    for (int i = 0; i < 16; i++)
      if (tab[i] == p) return i;
    return -1;
  endfunction

  function automatic int sat(input int c);
    return (c >= 255) ? 255 : c + 1;
  endfunction

  task automatic model_reset();
    m_digit = 0; m_valid = 0; m_dir = 0; m_cp = 0; m_inv = 0;
    m_up = 0; m_down = 0; m_err = 0; m_last = -1; m_streak = 0;
  endtask

  task automatic model_step(input logic [6:0] p, input logic e);
    int v;
    int delta;
    m_cp  = 0;
    m_inv = 0;
    if (!e) return;
    v = dec(p);
    if (v < 0) begin
      m_inv = 1; m_err = sat(m_err); m_last = -1; m_streak = 0;
      return;
    end
    // Showing the already accepted digit with nothing pending is a no-op.
    if (m_valid != 0 && m_last < 0 && v == m_digit) return;
    if (v == m_last) m_streak++;
    else begin m_last = v; m_streak = 1; end
    if (m_streak >= STABLE) begin
      if (m_valid != 0 && v != m_digit) begin
        m_cp  = 1;
        delta = (v - m_digit + 16) % 16;
        if (delta == 1)       begin m_dir = 1; m_up = sat(m_up); end
        else if (v == 0)      m_dir = 3;
        else if (delta == 15) begin m_dir = 2; m_down = sat(m_down); end
        else                  begin m_dir = 0; m_err = sat(m_err); end
      end else begin
        m_dir = 0;
      end
      m_digit = v; m_valid = 1; m_last = -1; m_streak = 0;
    end
  endtask

  task automatic check_dut(input string t, input logic [3:0] dg, input logic vl,
                           input logic [1:0] dr, input logic cp, input logic iv,
                           input logic [7:0] u, input logic [7:0] d, input logic [7:0] e);
    chk({t, "_digit"}, int'(dg), m_digit);
    chk({t, "_valid"}, int'(vl), m_valid);
    chk({t, "_dir"},   int'(dr), m_dir);
    chk({t, "_cp"},    int'(cp), m_cp);
    chk({t, "_inv"},   int'(iv), m_inv);
    chk({t, "_up"},    int'(u),  m_up);
    chk({t, "_down"},  int'(d),  m_down);
    chk({t, "_err"},   int'(e),  m_err);
  endtask

  always @(negedge clk) begin
    check_dut("a", a_digit, a_valid, a_dir, a_cp, a_inv, a_up, a_down, a_err);
    check_dut("b", b_digit, b_valid, b_dir, b_cp, b_inv, b_up, b_down, b_err);
  end

  task automatic step(input logic [6:0] p, input logic e);
    seg = p;
    en  = e;
    @(posedge clk);
    #1;
    model_step(p, e);
  endtask

  task automatic hold(input int d);
    step(tab[d], 1'b1);
    step(tab[d], 1'b1);
  endtask

  initial begin
    model_reset();
    rst = 1'b1;
    en  = 1'b0;
    seg = 7'h00;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_valid", int'(a_valid), 0);
    chk("reset_digit", int'(a_digit), 0);
    rst = 1'b0;

    // Two strobes of zero: accepted on the second, first-acceptance rules.
    step(7'h3F, 1'b1);
    chk("first_strobe_valid", int'(a_valid), 0);
    step(7'h3F, 1'b1);
    chk("zero_valid", int'(a_valid), 1);
    chk("zero_digit", int'(a_digit), 0);
    chk("zero_dir", int'(a_dir), 0);
    chk("zero_cp", int'(a_cp), 0);

    // Up steps 1,2,3.
    for (int d = 1; d <= 3; d++) begin
      hold(d);
      chk("up_cp", int'(a_cp), 1);
    end
    chk("up_count3", int'(a_up), 3);
    chk("up_dir", int'(a_dir), 1);
    chk("up_digit", int'(a_digit), 3);

    // Down steps, an unclassified jump, then back to zero.
    hold(2);
    hold(1);
    chk("down_count2", int'(b_down), 2);
    chk("down_dir", int'(b_dir), 2);
    hold(5);
    chk("jump_err", int'(a_err), 1);
    hold(0);
    chk("zero_ret_dir", int'(a_dir), 3);
    chk("zero_ret_up", int'(a_up), 3);
    chk("zero_ret_down", int'(a_down), 2);

    // Strobe low: no state change whatever the pattern.
    step(7'h00, 1'b0);
    step(7'h7F, 1'b0);
    step(7'h06, 1'b0);
    chk("idle_inv", int'(a_inv), 0);
    chk("idle_digit", int'(a_digit), 0);

    // Invalid pattern while locked at 7.
    hold(7);
    step(7'h00, 1'b1);
    chk("inv_pulse", int'(a_inv), 1);
    chk("inv_err", int'(a_err), 3);
    chk("inv_digit", int'(a_digit), 7);
    chk("inv_valid", int'(a_valid), 1);
    step(tab[7], 1'b0);
    chk("inv_pulse_end", int'(a_inv), 0);

    // Re-acceptance of the same digit after a transient candidate.
    hold(8);
    chk("up8_dir", int'(a_dir), 1);
    step(tab[9], 1'b1);
    hold(8);
    chk("reacc_dir", int'(a_dir), 0);
    chk("reacc_cp", int'(a_cp), 0);
    chk("reacc_digit", int'(a_digit), 8);

    // Invalid mid-settle breaks the run.
    step(tab[9], 1'b1);
    step(7'h00, 1'b1);
    step(tab[9], 1'b1);
    chk("broken_run_digit", int'(a_digit), 8);
    step(tab[9], 1'b1);
    chk("run_done_digit", int'(a_digit), 9);
    chk("run_done_up", int'(a_up), 5);

    // Alternating candidates never qualify; then reset mid-settle.
    step(tab[4], 1'b1);
    step(tab[5], 1'b1);
    chk("alt_digit", int'(a_digit), 9);
    #3;
    rst = 1'b1;
    model_reset();
    #1;
    chk("async_digit", int'(a_digit), 0);
    chk("async_valid", int'(b_valid), 0);
    chk("async_up", int'(a_up), 0);
    chk("async_err", int'(b_err), 0);
    chk("async_down", int'(a_down), 0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    hold(0);
    chk("post_reset_valid", int'(a_valid), 1);
    chk("post_reset_dir", int'(a_dir), 0);

    // 300 up steps with wrap: up_count saturates.
    for (int i = 1; i <= 300; i++) hold(i % 16);
    chk("sat_up_a", int'(a_up), 255);
    chk("sat_up_b", int'(b_up), 255);
    chk("sat_down", int'(b_down), 0);
    chk("sat_err", int'(b_err), 0);
    chk("sat_digit", int'(b_digit), 12);

    @(negedge clk);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/seg_decode_monitor.md
SEG_DECODE_MONITOR -- requirements
Module: seg_decode_monitor

Interface
REQ-001 Parameter STABLE_SAMPLES, default 2, consecutive identical sampled patterns required before a digit is accepted (legal range 1..15).
REQ-002 Parameter ACTIVE_LOW, default 1; when 1, segments_in is inverted before decoding.
REQ-003 clk_1hz  input  1  sole clock; all state changes on its rising edge.
REQ-004 reset_button  input  1  reset, asynchronous, active-high.
REQ-005 segments_in  input  7  seven-segment drive {g,f,e,d,c,b,a} under observation.
REQ-006 sample_en  input  1  one-cycle strobe; segments_in is sampled only when high.
REQ-007 digit_out  output  4  last accepted hex digit.
REQ-008 digit_valid  output  1  high once any digit has been accepted since reset.
REQ-009 dir_out  output  2  classification of last accepted change: 00 hold/first, 01 up, 10 down, 11 reset-to-zero.
REQ-010 change_pulse  output  1  one-cycle pulse when an accepted digit differs from the previous one.
REQ-011 invalid_pattern  output  1  one-cycle pulse on a sampled pattern outside the decode table.
REQ-012 up_count, down_count, err_count  output  8 each  saturating event counters.

Function
REQ-013 Decode table (active-high, gfedcba) SHALL be: 0=3F 1=06 2=5B 3=4F 4=66 5=6D 6=7D 7=07 8=7F 9=6F A=77 b=7C C=39 d=5E E=79 F=71; every other pattern SHALL be invalid.
REQ-014 FSM SHALL have states IDLE (no valid digit), SETTLE (candidate pattern being qualified), LOCKED (digit accepted).
REQ-015 IDLE: sample_en with valid pattern -> load candidate, run=1, go SETTLE (or accept immediately if STABLE_SAMPLES=1).
REQ-016 SETTLE: sample_en with pattern equal to candidate -> run+1; when run reaches STABLE_SAMPLES, accept at that edge and go LOCKED.
REQ-017 SETTLE: sample_en with different valid pattern -> replace candidate, run=1, stay SETTLE.
REQ-018 LOCKED: sample_en with pattern equal to digit_out -> no change, candidate cleared; different valid pattern -> candidate loaded, go SETTLE; digit_out held throughout.
REQ-019 Invalid pattern on sample_en in any state SHALL pulse invalid_pattern, increment err_count, clear candidate/run, and return to LOCKED if digit_valid else IDLE.
REQ-020 Acceptance SHALL update digit_out, digit_valid, dir_out, change_pulse and counters on the same qualifying edge (zero added latency).
REQ-021 First acceptance after reset: dir_out=00, change_pulse=0, no counter increments.
REQ-022 Accepted new=old+1 mod 16 -> dir_out=01, up_count+1 (F->0 is up).
REQ-023 Accepted new=old-1 mod 16 -> dir_out=10, down_count+1 (0->F is down).
REQ-024 Accepted new=0 not covered by REQ-022 -> dir_out=11, no up/down increment.
REQ-025 Any other accepted change -> dir_out=11 not set; dir_out=00, err_count+1.
REQ-026 Re-acceptance of same digit after an intervening candidate SHALL set dir_out=00, change_pulse=0.
REQ-027 All counters SHALL saturate at 255 and never wrap.
REQ-028 sample_en low SHALL leave all state unchanged; change_pulse and invalid_pattern SHALL be low.

Reset
REQ-029 reset_button high SHALL immediately force IDLE, digit_out=0, digit_valid=0, dir_out=00, change_pulse=0, invalid_pattern=0, all counters=0, candidate/run cleared, including mid-SETTLE.
REQ-030 After deassertion, first sample_en SHALL be processed as in IDLE on the next rising edge.

Verification
REQ-031 Reset, then two strobes of 0x3F (ACTIVE_LOW=0) -> digit_out=0, digit_valid=1 after second strobe, dir_out=00, no change_pulse.
REQ-032 From 0, apply 1,2,3 each for two strobes -> three change_pulses, dir_out=01, up_count=3, digit_out=3.
REQ-033 From 3, apply 2 then 1 -> dir_out=10, down_count=2; then apply 0x3F from 5 -> dir_out=11, counts unchanged.
REQ-034 In LOCKED at 7, one strobe of 0x00 -> invalid_pattern pulse, err_count+1, digit_out stays 7, digit_valid=1.
REQ-035 Single strobe of 4 then 5 in SETTLE (never two equal) -> no acceptance, digit_out unchanged; assert reset mid-SETTLE -> all outputs zero asynchronously.
REQ-036 ACTIVE_LOW=1, 300 up-steps -> up_count=255 saturated, F->0 counted as up.
